// File: rtl/seq_mult_feed.sv
// seq_mult_feed: iterative shift-add unsigned multiplier, one multiplier bit per clock.
// Produces the 2*WIDTH-bit operand x for the downstream divide-by-255 stage.
// x is held stable between operations; done pulses for one cycle when x updates.
// Optional build macro: SEQ_MULT_EARLY_TERM_EN. When defined, an operation
// completes as soon as the remaining multiplier bits are all zero.
module seq_mult_feed #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   x
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_x;
    logic            r_busy;
    logic            r_done;

    state_t          w_state_nxt;
    logic [PW-1:0]   w_acc_nxt;
    logic [PW-1:0]   w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [PW-1:0]   w_x_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic [PW-1:0]   w_sum;
    logic [WIDTH-1:0] w_b_shr;
    logic            w_last;

    // Partial-product add for the current multiplier bit and the shifted multiplier.
    always_comb begin
        w_sum   = r_acc + (r_b[0] ? r_a : '0);
        w_b_shr = r_b >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
        w_last  = (w_b_shr == '0);
`else
        w_last  = (r_cnt == CW'(WIDTH - 1));
`endif
    end

    // Next-state and next-register values; outputs are registered from these.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_a_nxt     = PW'(a);
                    w_b_nxt     = b;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_acc_nxt  = w_sum;
                w_a_nxt    = r_a << 1;
                w_b_nxt    = w_b_shr;
                w_cnt_nxt  = r_cnt + CW'(1);
                w_busy_nxt = 1'b1;
                if (w_last) begin
                    w_x_nxt     = w_sum;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign x    = r_x;

endmodule

// File: tb/tb_seq_mult_feed.sv
// Self-checking bench for seq_mult_feed: directed test-plan cases plus random
// operands, checked against a plain-arithmetic product and latency model.
module tb_seq_mult_feed;

    localparam int unsigned WIDTH = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic              done;
    logic [2*WIDTH-1:0] x;

    int n_checks = 0;
    int n_errors = 0;

    seq_mult_feed #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .x     (x)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Number of RUN edges an operation with multiplier bv should take.
    function automatic int exp_lat(input logic [WIDTH-1:0] bv);
        int l;
`ifdef SEQ_MULT_EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < WIDTH; i++)
            if (bv[i]) l = i + 1;
`else
        l = WIDTH;
`endif
        return l;
    endfunction

    // One start pulse; checks latency, busy length, held x, product and done width.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv, input string tag);
        logic [2*WIDTH-1:0] x_prev;
        logic [2*WIDTH-1:0] exp_x;
        int lat;
        int cycles;
        int busy_cnt;
        logic early;
        x_prev = x;
        exp_x  = (2*WIDTH)'(ta) * (2*WIDTH)'(tbv);
        lat    = exp_lat(tbv);
        @(negedge clk);
        a = ta; b = tbv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cycles   = 1;
        busy_cnt = busy ? 1 : 0;
        early    = (!done && x !== x_prev);
        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cnt++;
            if (!done && x !== x_prev) early = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(done), 64'(1));
        check({tag, "_latency"}, 64'(cycles - 1), 64'(lat));
        check({tag, "_busy_len"}, 64'(busy_cnt), 64'(lat));
        check({tag, "_x_held"}, 64'(early), 64'(0));
        check({tag, "_x"}, 64'(x), 64'(exp_x));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
        check({tag, "_busy_after"}, 64'(busy), 64'(0));
        check({tag, "_x_after"}, 64'(x), 64'(exp_x));
    endtask

    initial begin
        int t;
        int t1;
        int seen;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_x", 64'(x), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));

        run_op(16'd50, 16'd51, "m50x51");
        check("m50x51_const", 64'(x), 64'h09F6);

        run_op(16'd255, 16'd32, "m255x32");
        check("y32", 64'(x / 255), 64'(32));
        run_op(16'd255, 16'd128, "m255x128");
        check("y128", 64'(x / 255), 64'(128));
        run_op(16'd255, 16'd17, "m255x17");
        check("y17", 64'(x / 255), 64'(17));

        run_op(16'hFFFF, 16'hFFFF, "mffff");
        check("mffff_const", 64'(x), 64'hFFFE0001);
        run_op(16'h1234, 16'h0000, "mb0");
        run_op(16'h0000, 16'hBEEF, "ma0");
        run_op(16'd9, 16'd1, "m9x1");
        run_op(16'd9, 16'h8000, "m9x8000");

        // Start held high: back-to-back ops, operand change during RUN.
        @(negedge clk);
        a = 16'd3; b = 16'd5; start = 1'b1;
        t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
            if (t == 5) a = 16'd7;
        end
        check("held_done1", 64'(done), 64'(1));
        check("held_x15", 64'(x), 64'(15));
        t1 = t;
        @(negedge clk);
        t++;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        check("held_done2", 64'(done), 64'(1));
        check("held_x35", 64'(x), 64'(35));
        check("held_period", 64'(t - t1), 64'(exp_lat(16'd5) + 2));
        repeat (4) @(negedge clk);
        check("held_stop_busy", 64'(busy), 64'(0));

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a = 16'd100; b = 16'd200; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_x", 64'(x), 64'(0));
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("arst_no_done", 64'(seen), 64'(0));
        run_op(16'd100, 16'd200, "m100x200");

        // Randomised operands, with some sparse multipliers.
        for (int i = 0; i < 25; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = (i % 3 == 0) ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom);
            run_op(ra, rb, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
